output_port_arbiter: RTL and testbench

Per-output-port switch allocator and flow controller for the 5-port XY-routing mesh router. It receives head-of-FIFO flits from the five input FIFOs that are routed to this output. It grants one input per packet using round-robin and holds that grant from header to tail (wormhole). It forwards flits to the downstream FIFO only when the downstream occupancy count shows free space. One instance is built per output direction inside each router.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/output_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_output_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit type codes, port indices and the
// output arbiter FSM state type.
package noc_pkg;

  localparam int FLIT_W = 32;

  localparam logic [1:0] FLIT_HDR    = 2'b00;
  localparam logic [1:0] FLIT_SINGLE = 2'b01;
  localparam logic [1:0] FLIT_BODY   = 2'b10;
  localparam logic [1:0] FLIT_TAIL   = 2'b11;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int SOUTH = 2;
  localparam int EAST  = 3;
  localparam int WEST  = 4;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

  function automatic logic isPacketStart(input logic [1:0] flitType);
    return (flitType == FLIT_HDR) || (flitType == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping at N_IN. The pointer register belongs to the caller.
module rr_arbiter #(
  parameter int N_IN  = 5,
  parameter int PTR_W = 3
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_IN; k++) begin
      idx = (int'(ptr) + k) % N_IN;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output wormhole switch allocator: round-robin grant per packet, lock
// from header to tail, and forward flits only when the downstream FIFO has room.
module output_port_arbiter #(
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int N_IN   = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_IN-1:0]          req_valid,
  input  logic [N_IN*FLIT_W-1:0]   req_flit,
  output logic [N_IN-1:0]          pop,
  input  logic [CNT_W-1:0]         count_in,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     push_out,
  output logic [N_IN-1:0]          grant,
  output logic                     busy,
  output logic                     protocol_err
);

  import noc_pkg::*;

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  arb_state_e        state_q;
  logic [N_IN-1:0]   grant_q;
  logic [PTR_W-1:0]  rrPtr_q;
  logic [PTR_W-1:0]  rrPtr_d;
  logic [FLIT_W-1:0] flitOut_q;
  logic              push_q;
  logic              err_q;

  logic [N_IN-1:0]   eligible;
  logic [N_IN-1:0]   rrGnt;
  logic              space;
  logic              ownerValid;
  logic              ownerStart;
  logic              errSet;
  logic              accValid;
  logic [FLIT_W-1:0] accFlit;
  logic [1:0]        accType;
  logic [PTR_W-1:0]  accIdx;

  // A head flit can only start a packet if it is a header or single flit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_IN; i++) begin
      eligible[i] = req_valid[i] && isPacketStart(req_flit[i*FLIT_W + FLIT_W-2 +: 2]);
    end
  end

  rr_arbiter #(
    .N_IN  (N_IN),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (eligible),
    .ptr (rrPtr_q),
    .gnt (rrGnt)
  );

  // The push already in flight is not yet reflected in count_in.
  assign space = (({1'b0, count_in} + (CNT_W+1)'(push_q)) < (CNT_W+1)'(DEPTH));

  assign ownerValid = |(req_valid & grant_q);
  assign ownerStart = |(eligible & grant_q);

  always_comb begin
    pop    = '0;
    errSet = 1'b0;
    if (!reset && enable) begin
      if (state_q == ST_IDLE) begin
        errSet = |(req_valid & ~eligible);
        if (space) pop = rrGnt;
      end else begin
        if (ownerStart) errSet = 1'b1;
        else if (ownerValid && space) pop = grant_q;
      end
    end
  end

  always_comb begin
    accFlit = '0;
    accIdx  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pop[i]) begin
        accFlit = req_flit[i*FLIT_W +: FLIT_W];
        accIdx  = PTR_W'(i);
      end
    end
  end

  assign accValid = |pop;
  assign accType  = accFlit[FLIT_W-1 -: 2];
  assign rrPtr_d  = (accIdx == PTR_W'(N_IN-1)) ? '0 : accIdx + 1'b1;

  // Single FSM process; enable=0 leaves pop at zero so nothing below moves
  // except push_q dropping after the last in-flight push.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rrPtr_q   <= '0;
      flitOut_q <= '0;
      push_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      push_q <= accValid;
      if (accValid) flitOut_q <= accFlit;
      if (errSet) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accValid) begin
            rrPtr_q <= rrPtr_d;
            if (accType == FLIT_HDR) begin
              state_q <= ST_LOCKED;
              grant_q <= pop;
            end
          end
        end
        ST_LOCKED: begin
          if (accValid && accType == FLIT_TAIL) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign flit_out     = flitOut_q;
  assign push_out     = push_q;
  assign grant        = grant_q;
  assign busy         = (state_q == ST_LOCKED);
  assign protocol_err = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus random
// packet traffic, all checked against a packet-level reference model.
module tb_output_port_arbiter;

  localparam int FLIT_W = 32;
  localparam int N_IN   = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int QD     = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [N_IN-1:0]        req_valid;
  logic [N_IN*FLIT_W-1:0] req_flit;
  logic [N_IN-1:0]        pop;
  logic [CNT_W-1:0]       count_in;
  logic [FLIT_W-1:0]      flit_out;
  logic                   push_out;
  logic [N_IN-1:0]        grant;
  logic                   busy;
  logic                   protocol_err;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .FLIT_W (FLIT_W),
    .N_IN   (N_IN),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_flit     (req_flit),
    .pop          (pop),
    .count_in     (count_in),
    .flit_out     (flit_out),
    .push_out     (push_out),
    .grant        (grant),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  int errors = 0;
  int checks = 0;

  // Input FIFO contents as seen by the router, one circular buffer per input.
  logic [31:0] fifoMem [N_IN][QD];
  int          rdPtr [N_IN];
  int          wrPtr [N_IN];

  // Reference model: packet owner, round-robin pointer, in-flight push.
  bit          mLocked;
  int          mOwner;
  int          mRr;
  bit          mErr;
  bit          mPush;
  logic [31:0] mFlit;

  bit              randomValid;
  logic [N_IN-1:0] lastPop;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int qLevel(input int i);
    return wrPtr[i] - rdPtr[i];
  endfunction

  task automatic pushFlit(input int i, input logic [31:0] f);
    fifoMem[i][wrPtr[i] % QD] = f;
    wrPtr[i]++;
  endtask

  task automatic pushPkt(input int i, input int len);
    if (len == 1) begin
      pushFlit(i, {2'b01, 30'($urandom)});
    end else begin
      pushFlit(i, {2'b00, 30'($urandom)});
      for (int b = 0; b < len - 2; b++) pushFlit(i, {2'b10, 30'($urandom)});
      pushFlit(i, {2'b11, 30'($urandom)});
    end
  endtask

  task automatic clearQueues();
    for (int i = 0; i < N_IN; i++) begin
      rdPtr[i] = 0;
      wrPtr[i] = 0;
    end
  endtask

  // One clock cycle: drive at negedge, check registered outputs and the
  // expected pop, then advance the model at the posedge.
  task automatic applyStimulus(input bit rst, input bit en, input int cnt);
    int              acc;
    bit              errNow;
    bit              spaceOk;
    logic [1:0]      t;
    logic [31:0]     f;
    logic [N_IN-1:0] expPop;
    logic [N_IN-1:0] expGrant;
    @(negedge clk);
    reset    = rst;
    enable   = en;
    count_in = CNT_W'(cnt);
    for (int i = 0; i < N_IN; i++) begin
      if (qLevel(i) > 0) begin
        req_valid[i] = !randomValid || ($urandom_range(0, 3) != 0);
        req_flit[i*FLIT_W +: FLIT_W] = fifoMem[i][rdPtr[i] % QD];
      end else begin
        req_valid[i] = 1'b0;
        req_flit[i*FLIT_W +: FLIT_W] = $urandom;
      end
    end
    #1;
    expGrant = mLocked ? (N_IN'(1) << mOwner) : '0;
    checkOutput("push_out", 64'(push_out), 64'(mPush));
    if (mPush) checkOutput("flit_out", 64'(flit_out), 64'(mFlit));
    checkOutput("grant", 64'(grant), 64'(expGrant));
    checkOutput("busy", 64'(busy), 64'(mLocked));
    checkOutput("protocol_err", 64'(protocol_err), 64'(mErr));

    acc     = -1;
    errNow  = 1'b0;
    spaceOk = (cnt + (mPush ? 1 : 0)) < DEPTH;
    if (!rst && en) begin
      if (!mLocked) begin
        for (int k = 0; k < N_IN; k++) begin
          int i;
          i = (mRr + k) % N_IN;
          t = req_flit[i*FLIT_W + 30 +: 2];
          if (req_valid[i] && t >= 2'd2) errNow = 1'b1;
          if (req_valid[i] && t < 2'd2 && acc < 0 && spaceOk) acc = i;
        end
      end else if (req_valid[mOwner]) begin
        t = req_flit[mOwner*FLIT_W + 30 +: 2];
        if (t < 2'd2) errNow = 1'b1;
        else if (spaceOk) acc = mOwner;
      end
    end
    expPop = (acc >= 0) ? (N_IN'(1) << acc) : '0;
    lastPop = pop;
    checkOutput("pop", 64'(pop), 64'(expPop));

    @(posedge clk);
    if (rst) begin
      mLocked = 1'b0; mOwner = 0; mRr = 0; mErr = 1'b0; mPush = 1'b0; mFlit = '0;
    end else begin
      mErr  = mErr | errNow;
      mPush = (acc >= 0);
      if (acc >= 0) begin
        f     = fifoMem[acc][rdPtr[acc] % QD];
        mFlit = f;
        rdPtr[acc]++;
        if (!mLocked) begin
          mRr = (acc + 1) % N_IN;
          if (f[31:30] == 2'b00) begin
            mLocked = 1'b1;
            mOwner  = acc;
          end
        end else if (f[31:30] == 2'b11) begin
          mLocked = 1'b0;
        end
      end
    end
  endtask

  initial begin
    clearQueues();
    randomValid = 1'b0;
    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    req_flit  = '0;
    count_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_flit_out", 64'(flit_out), 64'd0);
    checkOutput("rst_push_out", 64'(push_out), 64'd0);
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(protocol_err), 64'd0);
    checkOutput("rst_pop", 64'(pop), 64'd0);
    mLocked = 1'b0; mOwner = 0; mRr = 0; mErr = 1'b0; mPush = 1'b0; mFlit = '0;

    // Single three-flit packet on input 0.
    pushFlit(0, 32'h0300_0025);
    pushFlit(0, 32'h8888_8822);
    pushFlit(0, 32'hC030_0024);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 0);
      checkOutput("t1_pop", 64'(lastPop), 64'h01);
    end
    repeat (2) applyStimulus(1'b0, 1'b1, 0);

    // Round robin from pointer 2 over inputs 1, 3, 4.
    clearQueues();
    pushPkt(1, 1);
    applyStimulus(1'b0, 1'b1, 0);
    pushPkt(1, 1); pushPkt(3, 1); pushPkt(4, 1);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t2_first", 64'(lastPop), 64'h08);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t2_second", 64'(lastPop), 64'h10);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t2_third", 64'(lastPop), 64'h02);

    // Wormhole lock on input 2 blocks a header waiting on input 0.
    clearQueues();
    pushPkt(2, 4);
    applyStimulus(1'b0, 1'b1, 0);
    pushPkt(0, 2);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 0);
      checkOutput("t3_locked_pop", 64'(lastPop), 64'h04);
    end
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t3_after_tail", 64'(lastPop), 64'h01);
    repeat (3) applyStimulus(1'b0, 1'b1, 0);

    // Backpressure near a full downstream FIFO.
    clearQueues();
    pushPkt(1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("t4_accept", 64'(lastPop), 64'h02);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("t4_inflight_block", 64'(lastPop), 64'h00);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("t4_full_block", 64'(lastPop), 64'h00);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("t4_resume", 64'(lastPop), 64'h02);
    repeat (4) applyStimulus(1'b0, 1'b1, 0);

    // Random traffic with bubbles, enable drops and varying occupancy.
    clearQueues();
    randomValid = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (qLevel(i) < 8 && $urandom_range(0, 3) == 0) pushPkt(i, $urandom_range(1, 5));
      end
      applyStimulus(1'b0, $urandom_range(0, 9) != 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0);
    end
    randomValid = 1'b0;
    repeat (200) applyStimulus(1'b0, 1'b1, 0);

    // Body flit at an idle head is a protocol error and is never popped.
    clearQueues();
    pushFlit(4, 32'h8888_8812);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t5_no_pop", 64'(lastPop), 64'h00);
    #1;
    checkOutput("t5_err_set", 64'(protocol_err), 64'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t5_still_no_pop", 64'(lastPop), 64'h00);

    // Reset while locked on input 1, then input 0 wins from pointer 0.
    clearQueues();
    pushPkt(1, 5);
    repeat (2) applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 0);
    clearQueues();
    #1;
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_grant", 64'(grant), 64'd0);
    checkOutput("t6_push", 64'(push_out), 64'd0);
    checkOutput("t6_err", 64'(protocol_err), 64'd0);
    pushPkt(0, 2);
    pushPkt(3, 1);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("t6_new_grant", 64'(lastPop), 64'h01);
    repeat (4) applyStimulus(1'b0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
